// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, buffers {pc, instr} pairs in a QDEPTH-entry FIFO
// feeding decode over valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_queue #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_wait,
    input  logic        j_label,
    input  logic        b_label,
    input  logic        zero,
    input  logic [31:0] br_pc,
    input  logic [15:0] b_address,
    input  logic [25:0] j_address,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_redirect,
    output logic [31:0] perf_stall
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          redir;
    logic          pop;
    logic          push;
    logic          full;
    logic [31:0]   pc4;
    logic [31:0]   target;

    assign redir = j_label | (b_label & zero);
    assign pc4   = br_pc + 32'd4;
    // Jump takes priority over a simultaneously resolving taken branch.
    assign target = j_label ? {pc4[31:28], j_address, 2'b00}
                            : pc4 + {{14{b_address[15]}}, b_address, 2'b00};

    assign full     = (count == CW'(QDEPTH));
    assign id_valid = (count != '0);
    assign pop      = id_valid & id_ready;
    assign push     = ~redir & ~imem_wait & (~full | pop);

    assign imem_addr = pc;
    assign id_instr  = q_instr[rd_ptr];
    assign id_pc     = q_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redir) begin
            // Whole queue is discarded; any concurrent pop is moot.
            pc     <= target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= pc;
                q_instr[wr_ptr] <= imem_rdata;
                wr_ptr          <= wr_ptr + AW'(1);
                pc              <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch    <= '0;
            perf_redirect <= '0;
            perf_stall    <= '0;
        end else begin
            if (push && perf_fetch != '1) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (redir && perf_redirect != '1) begin
                perf_redirect <= perf_redirect + 32'd1;
            end
            if (full && !pop && !redir && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, a redirect
// vector table, hand sequences for stall/wait/reset, and a randomized phase.
module tb_fetch_queue;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_wait;
    logic        j_label;
    logic        b_label;
    logic        zero;
    logic [31:0] br_pc;
    logic [15:0] b_address;
    logic [25:0] j_address;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_redirect;
    logic [31:0] perf_stall;
`endif

    fetch_queue #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_wait  (imem_wait),
        .j_label    (j_label),
        .b_label    (b_label),
        .zero       (zero),
        .br_pc      (br_pc),
        .b_address  (b_address),
        .j_address  (j_address),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_redirect (perf_redirect),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc;
    int unsigned m_fetch, m_redirect, m_stall;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check32("imem_addr", imem_addr, m_pc);
        check32("id_valid", {31'd0, id_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check32("id_pc", id_pc, q[0].pc);
            check32("id_instr", id_instr, q[0].instr);
        end
`ifdef FETCH_PERF_CNT_EN
        check32("perf_fetch", perf_fetch, m_fetch);
        check32("perf_redirect", perf_redirect, m_redirect);
        check32("perf_stall", perf_stall, m_stall);
`endif
    endtask

    // One clock: model computes the effect of the current inputs, then both sides are compared.
    task automatic step();
        bit          redir, pop, push, stall;
        logic [31:0] tgt;
        redir = j_label || (b_label && zero);
        pop   = (q.size() != 0) && id_ready;
        push  = !redir && !imem_wait && ((q.size() < QD) || pop);
        stall = (q.size() == QD) && !pop && !redir;
        if (j_label)
            tgt = ((br_pc + 32'd4) & 32'hF000_0000) | (32'(j_address) * 32'd4);
        else
            tgt = br_pc + 32'd4 + 32'($signed(b_address) * 4);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_pc = RPC;
            m_fetch = 0; m_redirect = 0; m_stall = 0;
        end else if (redir) begin
            q.delete();
            m_pc = tgt;
            m_redirect++;
        end else begin
            if (stall) m_stall++;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fetch++;
            end
        end
        #1;
        check_model();
    endtask

    task automatic clear_redirect();
        j_label = 0; b_label = 0; zero = 0;
        br_pc = 0; b_address = 0; j_address = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    typedef struct {
        logic        j;
        logic        b;
        logic        z;
        logic [31:0] bpc;
        logic [15:0] boff;
        logic [25:0] jadr;
        logic [31:0] exp_pc;
    } redir_vec_t;

    redir_vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 16'hFFFE, 26'h0,       32'h0000_0004};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h1000_0000, 16'h0010, 26'h40,      32'h1000_0100};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 16'h0010, 26'h0,       32'h0000_0144};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h2FFF_FFFC, 16'h0,    26'h3FF_FFFF, 32'h3FFF_FFFC};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 16'h0004, 26'h0,       32'h0000_000C};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 16'h8000, 26'h0,       32'hFFFE_0014};

        rst = 1; imem_wait = 0; id_ready = 0;
        clear_redirect();
        q.delete(); m_pc = RPC; m_fetch = 0; m_redirect = 0; m_stall = 0;

        // Reset state
        step();
        step();
        check32("rst_imem_addr", imem_addr, RPC);
        check32("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check32("rst_id_pc", id_pc, 32'd0);
        check32("rst_id_instr", id_instr, 32'd0);

        // Streaming start-up: id_pc 0,4,8,12 starting one cycle after reset release
        rst = 0; id_ready = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            check32("stream_valid", {31'd0, id_valid}, 32'd1);
            check32("stream_pc", id_pc, 32'(k * 4));
        end

        // Full-queue stall then drain
        do_reset();
        id_ready = 0;
        for (int k = 0; k < 6; k++) step();
        check32("stall_addr_hold", imem_addr, 32'd16);
`ifdef FETCH_PERF_CNT_EN
        check32("stall_perf_stall", perf_stall, 32'd2);
        check32("stall_perf_redirect", perf_redirect, 32'd0);
`endif
        id_ready = 1;
        for (int k = 0; k < 5; k++) begin
            check32("drain_valid", {31'd0, id_valid}, 32'd1);
            check32("drain_pc", id_pc, 32'(k * 4));
            step();
        end

        // imem_wait while a full queue drains
        do_reset();
        id_ready = 0;
        for (int k = 0; k < 6; k++) step();
        id_ready = 1; imem_wait = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check32("wait_addr_hold", imem_addr, 32'd16);
        end
        check32("wait_head_pc", id_pc, 32'd12);
        imem_wait = 0;
        step();
        check32("wait_resume_pc", id_pc, 32'd16);
        check32("wait_resume_addr", imem_addr, 32'd20);

        // Redirect table: flush, one bubble, then the target at the head
        for (int i = 0; i < 6; i++) begin
            step();
            step();
            j_label = vecs[i].j; b_label = vecs[i].b; zero = vecs[i].z;
            br_pc = vecs[i].bpc; b_address = vecs[i].boff; j_address = vecs[i].jadr;
            step();
            clear_redirect();
            check32("redir_bubble", {31'd0, id_valid}, 32'd0);
            check32("redir_addr", imem_addr, vecs[i].exp_pc);
            step();
            check32("redir_valid", {31'd0, id_valid}, 32'd1);
            check32("redir_target", id_pc, vecs[i].exp_pc);
        end

        // Not-taken branch leaves the stream untouched
        step();
        begin
            logic [31:0] prev;
            prev = id_pc;
            b_label = 1; zero = 0; br_pc = 32'h40; b_address = 16'h0100;
            step();
            clear_redirect();
            check32("not_taken_seq", id_pc, prev + 32'd4);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            imem_wait = ($urandom_range(0, 3) == 0);
            id_ready  = ($urandom_range(0, 3) != 0);
            j_label   = ($urandom_range(0, 15) == 0);
            b_label   = ($urandom_range(0, 7) == 0);
            zero      = $urandom_range(0, 1) == 1;
            br_pc     = $urandom() & 32'hFFFF_FFFC;
            b_address = 16'($urandom());
            j_address = 26'($urandom());
            step();
        end
        rst = 0;
        clear_redirect();

        // Reset mid-run overrides a simultaneous jump
        imem_wait = 0; id_ready = 1;
        for (int k = 0; k < 5; k++) step();
        rst = 1; j_label = 1; br_pc = 32'h1000_0000; j_address = 26'h40;
        step();
        rst = 0;
        clear_redirect();
        check32("midrst_valid", {31'd0, id_valid}, 32'd0);
        check32("midrst_addr", imem_addr, RPC);
`ifdef FETCH_PERF_CNT_EN
        check32("midrst_perf_fetch", perf_fetch, 32'd0);
        check32("midrst_perf_redirect", perf_redirect, 32'd0);
        check32("midrst_perf_stall", perf_stall, 32'd0);
`endif
        step();
        check32("midrst_first_pc", id_pc, RPC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
